prefetch_fetch_unit: RTL and testbench

Parametrised fetch stage for the pipelined RV32 core that replaces the single PC register with a decoupled instruction prefetch queue. It issues in-order requests to an instruction memory over a valid/ready request channel with variable response latency. It buffers up to DEPTH instructions and presents them to the Decode stage with a valid flag. On an Execute-stage redirect it discards every queued and in-flight instruction and restarts fetching at the target PC.

---
 rtl/prefetch_fetch_unit_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/prefetch_fetch_unit.sv | 106 ++++++++++
 tb/tb_prefetch_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared core definitions used by the fetch stage.
package prefetch_fetch_unit_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; head word is read straight from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt_q;

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Decoupled instruction prefetch stage: issues in-order fetches, queues
// returned instructions for Decode and flushes on an Execute redirect.
module prefetch_fetch_unit
  import prefetch_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            pc_srcE,
  input  logic [XLEN-1:0] pc_targetE,
  input  logic            stallD,
  output logic            validD,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D
);

  localparam int unsigned     CW      = $clog2(DEPTH) + 1;
  localparam int unsigned     EW      = XLEN + ILEN;
  localparam logic [CW:0]     DEPTH_C = DEPTH[CW:0];
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc_reqF;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] issued_pc;
  logic [EW-1:0]   head_entry;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   drop_cnt;
  logic            accept;
  logic            rsp_keep;
  logic            pop;

  assign imem_req_valid = !reset && !pc_srcE &&
                          (({1'b0, cnt} + {1'b0, out_cnt}) < DEPTH_C);
  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !pc_srcE;
  assign validD   = (cnt != '0);
  assign pop      = validD && !stallD && !pc_srcE;
  assign imem_addr = pc_reqF;

  assign head_pc    = head_entry[EW-1:ILEN];
  assign head_instr = head_entry[ILEN-1:0];

  // Decoded instruction queue; a redirect flushes it in one edge.
  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (pc_srcE),
    .push      (rsp_keep),
    .push_data ({issued_pc, imem_rsp_data}),
    .pop       (pop),
    .head_data (head_entry),
    .count     (cnt)
  );

  // Issued-PC queue; its occupancy is exactly the outstanding-request count,
  // so it doubles as out_cnt. Never flushed: stale responses still pop it.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (accept),
    .push_data (pc_reqF),
    .pop       (imem_rsp_valid),
    .head_data (issued_pc),
    .count     (out_cnt)
  );

  // Fetch PC: redirect wins, otherwise advance on each accepted request.
  always_ff @(posedge clk) begin
    if (reset)        pc_reqF <= RESET_PC;
    else if (pc_srcE) pc_reqF <= pc_targetE;
    else if (accept)  pc_reqF <= pc_reqF + PC_STEP;
  end

  // Stale-response counter. On redirect every request still outstanding after
  // this cycle is stale; already-doomed ones are part of out_cnt, so the new
  // value is out_cnt minus any response consumed now (accumulates correctly).
  always_ff @(posedge clk) begin
    if (reset)                                  drop_cnt <= '0;
    else if (pc_srcE)                           drop_cnt <= out_cnt - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && drop_cnt != '0)  drop_cnt <= drop_cnt - CW'(1);
  end

  // Remember the last presented PC so pcD holds while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset)       last_pc <= '0;
    else if (validD) last_pc <= head_pc;
  end

  assign instrD    = validD ? head_instr : NOP_INSTR;
  assign pcD       = validD ? head_pc : last_pc;
  assign pc_plus4D = pcD + PC_STEP;

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Self-checking bench for prefetch_fetch_unit with a variable-latency memory.
module tb_prefetch_fetch_unit;
  import prefetch_fetch_unit_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pc_srcE;
  logic [31:0] pc_targetE;
  logic        stallD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;

  prefetch_fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_srcE        (pc_srcE),
    .pc_targetE     (pc_targetE),
    .stallD         (stallD),
    .validD         (validD),
    .instrD         (instrD),
    .pcD            (pcD),
    .pc_plus4D      (pc_plus4D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  int cyc, last_due;
  int ready_pct, lat_min, lat_max, stall_pct, redir_pct;
  bit force_redir;
  logic [31:0] force_target;

  // Reference model: the fetch address stream and the Decode PC stream are
  // both linear runs of +4 restarted by each redirect.
  logic [31:0] fetch_pc, exp_pc;
  int pops, accepts, first_valid;
  bit last_req, last_valid, track_pop;
  logic [31:0] last_pcD, first_pop_pc, first_pop_p4;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; pc_srcE = 1'b0; pc_targetE = '0; stallD = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_validD", 32'(validD), 32'd0);
    check_eq("rst_instrD", instrD, NOP_INSTR);
    check_eq("rst_pcD", pcD, 32'h0);
    check_eq("rst_pc_plus4D", pc_plus4D, 32'h4);
    mq.delete();
    cyc = 0; last_due = -1;
    fetch_pc = RESET_PC; exp_pc = RESET_PC;
    pops = 0; accepts = 0; first_valid = -1;
    force_redir = 1'b0; track_pop = 1'b0;
  endtask

  task automatic cycle();
    int lat, due;
    @(negedge clk);
    reset = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end
    imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    stallD         = ($urandom_range(0, 99) < stall_pct);
    pc_srcE        = force_redir || ($urandom_range(0, 99) < redir_pct);
    pc_targetE     = force_redir ? force_target : ($urandom() & 32'hFFFF_FFFC);
    #1;
    last_req = imem_req_valid; last_valid = validD; last_pcD = pcD;
    if (validD && first_valid < 0) first_valid = cyc;
    if (!validD) check_eq("nop_when_empty", instrD, NOP_INSTR);
    if (imem_req_valid) check_eq("imem_addr", imem_addr, fetch_pc);
    if (pc_srcE) begin
      check_eq("req_in_redirect", 32'(imem_req_valid), 32'd0);
      fetch_pc  = pc_targetE;
      exp_pc    = pc_targetE;
      track_pop = 1'b1;
    end else begin
      if (validD && !stallD) begin
        check_eq("pcD", pcD, exp_pc);
        check_eq("instrD", instrD, instr_of(exp_pc));
        check_eq("pc_plus4D", pc_plus4D, exp_pc + 32'd4);
        if (track_pop) begin
          first_pop_pc = pcD; first_pop_p4 = pc_plus4D; track_pop = 1'b0;
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (imem_req_valid && imem_req_ready) begin
        lat = $urandom_range(lat_min, lat_max);
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        mq.push_back('{addr: imem_addr, due: due});
        fetch_pc = fetch_pc + 32'd4;
        accepts++;
      end
    end
    @(posedge clk);
    cyc++;
    force_redir = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    pc_srcE = 1'b0; pc_targetE = '0; stallD = 1'b0;
    redir_pct = 0; force_redir = 1'b0; force_target = '0;

    // Streaming with a 1-cycle memory that always accepts.
    ready_pct = 100; lat_min = 1; lat_max = 1; stall_pct = 0;
    do_reset();
    repeat (12) cycle();
    check_eq("first_valid_cycle", 32'(first_valid), 32'd2);
    check_eq("stream_pops", 32'(pops), 32'd10);
    check_eq("stream_accepts", 32'(accepts), 32'd12);

    // Decode stalled: issue stops once DEPTH instructions are owned.
    stall_pct = 100;
    do_reset();
    repeat (8) cycle();
    check_eq("stall_accepts", 32'(accepts), 32'd4);
    check_eq("stall_req_low", 32'(last_req), 32'd0);
    check_eq("stall_no_pop", 32'(pops), 32'd0);
    stall_pct = 0;
    repeat (8) cycle();
    check_eq("stall_release_pops", 32'(pops >= 4), 32'd1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    repeat (2) cycle();
    force_redir = 1'b1; force_target = 32'h400;
    cycle();
    repeat (10) cycle();
    check_eq("redirect_first_pc", first_pop_pc, 32'h400);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (5) cycle();
    force_redir = 1'b1; force_target = 32'h800;
    cycle();
    cycle();
    check_eq("redir_empty_t1", 32'(last_valid), 32'd0);
    cycle();
    check_eq("redir_empty_t2", 32'(last_valid), 32'd0);
    cycle();
    check_eq("redir_valid_t3", 32'(last_valid), 32'd1);
    check_eq("redir_pc_t3", last_pcD, 32'h800);

    // Address wrap at the top of the address space.
    do_reset();
    repeat (3) cycle();
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    cycle();
    repeat (6) cycle();
    check_eq("wrap_pc", first_pop_pc, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", first_pop_p4, 32'h0);

    // Randomised traffic, with a reset in the middle of operation.
    ready_pct = 70; lat_min = 1; lat_max = 5; stall_pct = 30; redir_pct = 3;
    do_reset();
    repeat (1500) cycle();
    check_eq("random_progress_a", 32'(pops >= 100), 32'd1);
    do_reset();
    repeat (1500) cycle();
    check_eq("random_progress_b", 32'(pops >= 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
